// File: rtl/mmult_opt_mdc_package.sv
// Shared control/status structs and FSM encoding for the MDC MAC engine.
package mmult_opt_mdc_package;

  localparam int unsigned CNT_WIDTH = 16;

  typedef struct packed {
    logic                 start;
    logic [CNT_WIDTH-1:0] len;
    logic [CNT_WIDTH-1:0] n_out;
  } ctrl_engine_t;

  typedef struct packed {
    logic                 busy;
    logic                 done;
    logic [CNT_WIDTH-1:0] out_cnt;
  } flags_engine_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_EMIT = 2'd2,
    ST_DONE = 2'd3
  } state_t;

endpackage

// File: rtl/mmult_opt_mdc_acc_narrow.sv
// Narrows the wide signed accumulator to the stream width; combinational.
// MMULT_OPT_MDC_SAT_EN selects signed saturation, otherwise the low bits wrap.
module mmult_opt_mdc_acc_narrow #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 64
) (
  input  logic signed [ACC_WIDTH-1:0]  acc_i,
  output logic        [DATA_WIDTH-1:0] data_o
);

`ifdef MMULT_OPT_MDC_SAT_EN
  localparam logic [DATA_WIDTH-1:0] DATA_MAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic [DATA_WIDTH-1:0] DATA_MIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX = ACC_WIDTH'(DATA_MAX);
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  always_comb begin
    data_o = acc_i[DATA_WIDTH-1:0];
    if (acc_i > SAT_MAX)      data_o = DATA_MAX;
    else if (acc_i < SAT_MIN) data_o = DATA_MIN;
  end
`else
  logic unused_hi;
  assign unused_hi = ^acc_i[ACC_WIDTH-1:DATA_WIDTH];
  assign data_o    = acc_i[DATA_WIDTH-1:0];
`endif

endmodule

// File: rtl/mmult_opt_mdc_mac_engine.sv
// Streaming MAC: len signed A*B pairs per result, n_out results per job (MMULT_OPT_MDC_SAT_EN: saturate).
// Latency: out_r_valid rises the cycle after the last pair handshake.
// Backpressure: out_r holds until ready; inputs are only taken as a joint pair in ACC.
module mmult_opt_mdc_mac_engine
  import mmult_opt_mdc_package::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ACC_WIDTH  = 64
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    enable_i,
  input  logic                    clear_i,
  input  logic [DATA_WIDTH-1:0]   in1_data,
  input  logic                    in1_valid,
  output logic                    in1_ready,
  input  logic [DATA_WIDTH-1:0]   in2_data,
  input  logic                    in2_valid,
  output logic                    in2_ready,
  output logic [DATA_WIDTH-1:0]   out_r_data,
  output logic [DATA_WIDTH/8-1:0] out_r_strb,
  output logic                    out_r_valid,
  input  logic                    out_r_ready,
  input  ctrl_engine_t            ctrl_i,
  output flags_engine_t           flags_o
);

  state_t                      state;
  logic signed [ACC_WIDTH-1:0] acc;
  logic signed [ACC_WIDTH-1:0] a_ext;
  logic signed [ACC_WIDTH-1:0] b_ext;
  logic signed [ACC_WIDTH-1:0] prod;
  logic [CNT_WIDTH-1:0]        k_cnt;
  logic [CNT_WIDTH-1:0]        out_cnt;
  logic [CNT_WIDTH-1:0]        len_q;
  logic [CNT_WIDTH-1:0]        n_out_q;
  logic                        pair_fire;
  logic                        out_fire;
  logic                        last_pair;
  logic                        last_out;

  // A zero-length result never consumes operands.
  assign pair_fire = (state == ST_ACC) && enable_i && in1_valid && in2_valid
                     && (len_q != '0);
  assign out_fire  = (state == ST_EMIT) && enable_i && out_r_ready;
  assign in1_ready = pair_fire;
  assign in2_ready = pair_fire;

  assign a_ext     = {{(ACC_WIDTH-DATA_WIDTH){in1_data[DATA_WIDTH-1]}}, in1_data};
  assign b_ext     = {{(ACC_WIDTH-DATA_WIDTH){in2_data[DATA_WIDTH-1]}}, in2_data};
  assign prod      = a_ext * b_ext;
  assign last_pair = (k_cnt == len_q - 16'd1);
  assign last_out  = ((out_cnt + 16'd1) == n_out_q);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= ST_IDLE;
      acc     <= '0;
      k_cnt   <= '0;
      out_cnt <= '0;
      len_q   <= '0;
      n_out_q <= '0;
    end else if (clear_i) begin
      state   <= ST_IDLE;
      acc     <= '0;
      k_cnt   <= '0;
      out_cnt <= '0;
    end else if (enable_i) begin
      case (state)
        ST_IDLE: if (ctrl_i.start) begin
          len_q   <= ctrl_i.len;
          n_out_q <= ctrl_i.n_out;
          acc     <= '0;
          k_cnt   <= '0;
          out_cnt <= '0;
          state   <= (ctrl_i.n_out == '0) ? ST_DONE : ST_ACC;
        end
        ST_ACC: begin
          if (len_q == '0) begin
            state <= ST_EMIT;
          end else if (pair_fire) begin
            acc   <= acc + prod;
            k_cnt <= k_cnt + 16'd1;
            if (last_pair) state <= ST_EMIT;
          end
        end
        ST_EMIT: if (out_fire) begin
          out_cnt <= out_cnt + 16'd1;
          acc     <= '0;
          k_cnt   <= '0;
          state   <= last_out ? ST_DONE : ST_ACC;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // Output data comes straight from the registered accumulator, so it is frozen in EMIT.
  mmult_opt_mdc_acc_narrow #(
    .DATA_WIDTH (DATA_WIDTH),
    .ACC_WIDTH  (ACC_WIDTH)
  ) u_narrow (
    .acc_i  (acc),
    .data_o (out_r_data)
  );

  assign out_r_valid = (state == ST_EMIT);
  assign out_r_strb  = '1;
  assign flags_o     = '{busy: (state != ST_IDLE), done: (state == ST_DONE), out_cnt: out_cnt};

endmodule
